// File: rtl/rst_manager.sv
// rst_manager: power-on hold and staggered multi-domain reset release,
// with debounced button, software and watchdog reset sources plus a sticky cause register.
module rst_manager #(
   parameter int HOLD_CYCLES = 65535,
   parameter int N_OUT       = 2,
   parameter int STAGGER     = 16,
   parameter int DEB_CYCLES  = 1024,
   parameter int WDT_CYCLES  = 1 << 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_i,
   input  logic             sw_rst_i,
   input  logic             wdt_en_i,
   input  logic             wdt_kick_i,
   output logic [N_OUT-1:0] rst_o,
   output logic             busy_o,
   output logic [1:0]       cause_o
);
   localparam int STG_T = (N_OUT - 1) * STAGGER;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int SW = $clog2(STG_T) + 1;
   localparam int DW = $clog2(DEB_CYCLES) + 1;
   localparam int WW = $clog2(WDT_CYCLES) + 1;
   localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STG_MAX = SW'(STG_T);
   localparam logic [DW-1:0] DEB_M1  = DW'(DEB_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
   localparam logic [WW-1:0] WDT_M1  = WW'(WDT_CYCLES - 1);

   typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;

   state_t           r_state;
   logic [HW-1:0]    r_hold;
   logic [SW-1:0]    r_stg;
   logic [N_OUT-1:0] r_rst;
   logic             r_busy;
   logic [1:0]       r_cause;
   logic             r_btn_s1;
   logic             r_btn_s2;
   logic [DW-1:0]    r_deb_cnt;
   logic             r_btn_deb;
   logic [WW-1:0]    r_wdt_cnt;

   logic [SW-1:0]    w_stg_n;
   logic [N_OUT-1:0] w_mask;
   logic             w_done;
   logic             w_wdt_exp;
   logic             w_trig;
   logic [1:0]       w_cause;

   assign rst_o   = r_rst;
   assign busy_o  = r_busy;
   assign cause_o = r_cause;

   always_comb begin
      w_wdt_exp = r_state == S_RUN && wdt_en_i && !wdt_kick_i && r_wdt_cnt == WDT_M1;
      w_trig    = r_btn_deb || w_wdt_exp || (sw_rst_i && r_state != S_ASSERT);
      w_cause   = r_btn_deb ? 2'd1 : w_wdt_exp ? 2'd3 : 2'd2;
      w_stg_n   = r_state != S_RELEASE ? '0 : r_stg == STG_MAX ? r_stg : r_stg + 1'b1;
      w_done    = int'(w_stg_n) >= STG_T;
      for (int k = 0; k < N_OUT; k++) w_mask[k] = int'(w_stg_n) < k * STAGGER;
   end

   // btn_deb rises on the edge the count would reach DEB_CYCLES
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_s1  <= 1'b0;
         r_btn_s2  <= 1'b0;
         r_deb_cnt <= '0;
         r_btn_deb <= 1'b0;
         r_wdt_cnt <= '0;
      end else begin
         r_btn_s1  <= btn_i;
         r_btn_s2  <= r_btn_s1;
         r_deb_cnt <= !r_btn_s2 ? '0 : r_deb_cnt == DEB_MAX ? r_deb_cnt : r_deb_cnt + 1'b1;
         r_btn_deb <= r_btn_s2 && r_deb_cnt >= DEB_M1;
         r_wdt_cnt <= (r_state != S_RUN || !wdt_en_i || wdt_kick_i || w_wdt_exp) ? '0 :
                      r_wdt_cnt == WDT_M1 ? r_wdt_cnt : r_wdt_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ASSERT;
         r_hold  <= '0;
         r_stg   <= '0;
         r_rst   <= '1;
         r_busy  <= 1'b1;
         r_cause <= 2'd0;
      end else if (w_trig) begin
         r_state <= S_ASSERT;
         r_hold  <= '0;
         r_stg   <= '0;
         r_rst   <= '1;
         r_busy  <= 1'b1;
         r_cause <= w_cause;
      end else begin
         case (r_state)
            S_ASSERT: begin
               if (r_hold == HOLD_M1) begin
                  r_state <= w_done ? S_RUN : S_RELEASE;
                  r_stg   <= w_stg_n;
                  r_rst   <= w_mask;
                  r_busy  <= !w_done;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            S_RELEASE: begin
               r_stg  <= w_stg_n;
               r_rst  <= w_mask;
               r_busy <= !w_done;
               if (w_done) r_state <= S_RUN;
            end
            S_RUN: begin
               r_rst  <= '0;
               r_busy <= 1'b0;
            end
            default: r_state <= S_ASSERT;
         endcase
      end
   end
endmodule

// File: tb/tb_rst_manager.sv
// tb_rst_manager: directed checks of release timing, reset sources, cause priority and master reset.
module tb_rst_manager;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_i = 1'b0;
   logic       sw_rst_i = 1'b0;
   logic       wdt_en_i = 1'b0;
   logic       wdt_kick_i = 1'b0;
   logic [2:0] rst_o;
   logic       busy_o;
   logic [1:0] cause_o;
   int         n_chk = 0;
   int         n_err = 0;

   rst_manager #(
      .HOLD_CYCLES(16),
      .N_OUT(3),
      .STAGGER(4),
      .DEB_CYCLES(8),
      .WDT_CYCLES(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_i(btn_i),
      .sw_rst_i(sw_rst_i),
      .wdt_en_i(wdt_en_i),
      .wdt_kick_i(wdt_kick_i),
      .rst_o(rst_o),
      .busy_o(busy_o),
      .cause_o(cause_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // e = edges since the trigger edge (or since rst fell); sw pulse injected at edge sw_at
   task automatic check_release(input string tag, input int sw_at);
      logic [2:0] exp;
      for (int e = 1; e <= 24; e++) begin
         sw_rst_i = (e == sw_at);
         tick();
         sw_rst_i = 1'b0;
         exp = e < 16 ? 3'b111 : e < 20 ? 3'b110 : e < 24 ? 3'b100 : 3'b000;
         check({tag, "_rst"}, 32'(rst_o), 32'(exp));
         check({tag, "_busy"}, 32'(busy_o), 32'(exp != 0));
      end
   endtask

   task automatic idle(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         seen = seen | busy_o | (|rst_o);
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   task automatic wdt_expire(input string tag);
      idle({tag, "_quiet"}, 99);
      tick();
      check({tag, "_rst"}, 32'(rst_o), 32'h7);
      check({tag, "_cause"}, 32'(cause_o), 32'd3);
   endtask

   initial begin
      // power-on
      repeat (3) tick();
      check("por_rst", 32'(rst_o), 32'h7);
      check("por_busy", 32'(busy_o), 32'd1);
      check("por_cause", 32'(cause_o), 32'd0);
      rst = 1'b0;
      check_release("por", 0);
      check("por_cause_end", 32'(cause_o), 32'd0);
      // software reset from RUN
      idle("run_idle", 5);
      sw_rst_i = 1'b1;
      tick();
      sw_rst_i = 1'b0;
      check("sw_rst", 32'(rst_o), 32'h7);
      check("sw_cause", 32'(cause_o), 32'd2);
      check_release("sw", 0);
      // short button glitch
      btn_i = 1'b1;
      repeat (5) tick();
      btn_i = 1'b0;
      idle("glitch", 25);
      // button held 40 cycles
      btn_i = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 10) check("btn_pre", 32'(rst_o), 32'h0);
         if (i == 11) check("btn_rst", 32'(rst_o), 32'h7);
         if (i == 11) check("btn_cause", 32'(cause_o), 32'd1);
      end
      check("btn_held", 32'(rst_o), 32'h7);
      btn_i = 1'b0;
      repeat (3) tick();
      check("btn_fall", 32'(rst_o), 32'h7);
      check_release("btn", 0);
      check("btn_cause_end", 32'(cause_o), 32'd1);
      // watchdog kicked every 50 cycles
      wdt_en_i = 1'b1;
      for (int j = 0; j < 4; j++) begin
         idle("wdt_kicked", 49);
         wdt_kick_i = 1'b1;
         tick();
         wdt_kick_i = 1'b0;
      end
      check("wdt_kick_busy", 32'(busy_o), 32'd0);
      wdt_expire("wdt");
      wdt_en_i = 1'b0;
      check_release("wdt", 0);
      idle("wdt_off", 150);
      // simultaneous sw and button accept
      btn_i = 1'b1;
      repeat (10) tick();
      check("sim_pre", 32'(rst_o), 32'h0);
      sw_rst_i = 1'b1;
      tick();
      sw_rst_i = 1'b0;
      btn_i = 1'b0;
      check("sim_rst", 32'(rst_o), 32'h7);
      check("sim_cause", 32'(cause_o), 32'd1);
      repeat (3) tick();
      check_release("sim", 0);
      // sw during ASSERT ignored
      sw_rst_i = 1'b1;
      tick();
      sw_rst_i = 1'b0;
      check("swa_cause", 32'(cause_o), 32'd2);
      check_release("swa", 5);
      // master reset mid-RELEASE after watchdog reset
      wdt_en_i = 1'b1;
      wdt_expire("wdt2");
      repeat (18) tick();
      check("mid_rel", 32'(rst_o), 32'h6);
      rst = 1'b1;
      wdt_en_i = 1'b0;
      tick();
      check("mrst_rst", 32'(rst_o), 32'h7);
      check("mrst_busy", 32'(busy_o), 32'd1);
      check("mrst_cause", 32'(cause_o), 32'd0);
      rst = 1'b0;
      check_release("por2", 0);
      check("por2_cause", 32'(cause_o), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/rst_manager.md
# rst_manager

Parametrised reset manager that sits between the board reset and the system/peripheral reset nets of a top-level wrapper. It produces multiple active-high reset outputs with a programmable power-on hold and staggered per-domain release. It also accepts three reset sources: a debounced external button, a software request and a watchdog timeout. The cause of the most recent reset is latched for firmware to read.

## Interface
- HOLD_CYCLES, 65535: cycles all outputs stay asserted after the last reset trigger clears; ≥1.
- N_OUT, 2: number of reset outputs; ≥1.
- STAGGER, 16: cycles between release of consecutive outputs; 0 releases all together.
- DEB_CYCLES, 1024: consecutive synchronised-high cycles required to accept the button; ≥1.
- WDT_CYCLES, 2^24: idle cycles in RUN, with the watchdog enabled and no kick, before a watchdog reset; ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high master reset.
- btn_i  in  1  external reset button, asynchronous, active-high.
- sw_rst_i  in  1  software reset request, single-cycle pulse, synchronous.
- wdt_en_i  in  1  watchdog enable, level.
- wdt_kick_i  in  1  watchdog kick, single-cycle pulse.
- rst_o  out  N_OUT  reset outputs, active-high; bit 0 releases first.
- busy_o  out  1  high while any rst_o bit is high.
- cause_o  out  2  last cause: 0 = power-on/master, 1 = button, 2 = software, 3 = watchdog.

## Operation
- States: ASSERT, RELEASE, RUN.
- ASSERT:
  - All rst_o = 1; hold counter increments each cycle.
  - When the counter reaches HOLD_CYCLES, go to RELEASE with the stagger counter at 0.
- RELEASE:
  - rst_o[0] is already low on entry.
  - rst_o[k] goes low when the stagger counter reaches k*STAGGER.
  - After rst_o[N_OUT-1] releases, go to RUN.
- RUN: all rst_o = 0; busy_o = 0.
- Trigger conditions:
  - btn_deb = 1.
  - sw_rst_i = 1 while in RELEASE or RUN.
  - Watchdog expiry in RUN.
- Effect of a trigger: go to ASSERT, clear the hold counter, set all rst_o = 1 on the next edge.
- Trigger during ASSERT: a button trigger restarts the hold count. Software and watchdog triggers are ignored in ASSERT.
- Button path:
  - 2-flop synchroniser, then debounce counter.
  - The counter clears on any synchronised low sample.
  - btn_deb = 1 once the counter reaches DEB_CYCLES; it stays 1 until a synchronised low sample.
  - A held button keeps the block in ASSERT; release starts HOLD_CYCLES after btn_deb falls.
- Watchdog:
  - Counter clears on wdt_kick_i, on wdt_en_i = 0, or in any state other than RUN.
  - Otherwise it increments.
  - Expiry occurs when the counter reaches WDT_CYCLES-1 without a kick; expiry clears the counter.
- cause_o:
  - Updated on each accepted trigger.
  - Priority on the same cycle: button > watchdog > software.
  - Cleared to 0 only by rst; it survives internally generated resets.
- Counter widths: $clog2 of the respective terminal value +1. Counters saturate; they never wrap.

## Timing
- While rst = 1: state ASSERT, all counters 0, rst_o = all ones, busy_o = 1, cause_o = 0, btn_deb = 0.
- The first edge with rst = 0 is edge 1.
- rst_o[0] = 0 after edge HOLD_CYCLES.
- rst_o[k] = 0 after edge HOLD_CYCLES + k*STAGGER.
- busy_o falls on the same edge as rst_o[N_OUT-1].
- sw_rst_i high at edge t: rst_o = all ones and cause_o updated after edge t.
- Button latency: btn_i stable high from edge t gives btn_deb = 1 after edge t+1+DEB_CYCLES, and rst_o all ones one edge later.
- rst asserted mid-operation: the next edge forces the reset state, including cause_o = 0.
- A btn_i glitch shorter than DEB_CYCLES cycles has no effect.
- Two triggers on the same edge count as one reset; cause_o follows the priority rule.

## Test plan
All cases use HOLD_CYCLES=16, N_OUT=3, STAGGER=4, DEB_CYCLES=8, WDT_CYCLES=100.
- Power-on: rst high 3 cycles, then low -> rst_o releases in order: bit 0 after edge 16, bit 1 after edge 20, bit 2 after edge 24; busy_o falls after edge 24; cause_o = 0.
- Software reset: in RUN, pulse sw_rst_i at edge t -> rst_o = 3'b111 after t; bit 0 low after t+16; cause_o = 2.
- Button: 5-cycle glitch -> no reset. Held 40 cycles -> rst_o all ones 10 edges after the rise and held; release sequence starts 16 cycles after btn_deb falls; cause_o = 1.
- Watchdog: wdt_en_i = 1 with a kick every 50 cycles -> no reset. Stop kicking -> reset 100 cycles after the last kick; cause_o = 3. Same run with wdt_en_i = 0 -> no reset.
- Simultaneous sw_rst_i and button accept -> single reset; cause_o = 1. sw_rst_i during ASSERT -> ignored; hold timing unchanged.
- Master rst asserted mid-RELEASE after a watchdog reset -> rst_o all ones next edge; cause_o = 0; full power-on sequence repeats.
